servo_pwm_gen: RTL and testbench

- Downstream consumer of the divided slow clock `sclk`.
- Resynchronises `sclk` into the `clk` domain and turns each rising edge into a one-cycle tick.
- Uses the ticks to generate a fixed-period servo PWM waveform.
- Pulse width comes from a position command. A new command is taken through a valid/ready handshake and applied only at a frame boundary, so no pulse is ever glitched.

---
 rtl/servo_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 14 +
 rtl/servo_pwm_gen.sv | 70 +++++++
 tb/tb_servo_pwm_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults, state encoding and counter-width helper for servo PWM blocks.
package servo_pkg;
  localparam int PERIOD_TICKS_DEF = 2000;
  localparam int MIN_TICKS_DEF = 100;
  localparam int POS_W_DEF = 8;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  function automatic int clog2(input int unsigned v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) r = ((32'd1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchroniser followed by a registered one-cycle rising-edge tick.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic tick_o
);
  logic sync1_q, sync2_q, prev_q, tick_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {sync1_q, sync2_q, prev_q, tick_q} <= '0;
    else {sync1_q, sync2_q, prev_q, tick_q} <= {d_i, sync1_q, sync2_q, sync2_q & ~prev_q};
  end
  assign tick_o = tick_q;
endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: fixed-period servo PWM clocked by sclk ticks; commands take effect only at frame wrap.
// Define SERVO_CLAMP_EN to clamp captured commands to POS_MAX.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEF,
  parameter int MIN_TICKS = MIN_TICKS_DEF,
  parameter int POS_W = POS_W_DEF
`ifdef SERVO_CLAMP_EN
  , parameter int POS_MAX = 180
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] pos_data,
  output logic             pos_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             active
);
  localparam int CNT_W = clog2(PERIOD_TICKS);
  logic tick, wrap, xfer, apply;
  logic [POS_W-1:0] pos_lim, shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, width_q, width_d;
  logic pending_q, pending_d, pwm_q, pwm_d, fs_q;
  state_e state_q, state_d;
  sync_edge_det u_sync (.clk(clk), .rst_n(rst_n), .d_i(sclk_in), .tick_o(tick));
`ifdef SERVO_CLAMP_EN
  assign pos_lim = (pos_data > POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : pos_data;
`else
  assign pos_lim = pos_data;
`endif
  assign wrap = tick && cnt_q == CNT_W'(PERIOD_TICKS - 1);
  assign xfer = pos_valid && !pending_q;
  // A wrap sees the pre-transfer shadow/pending, so a same-cycle command waits a frame.
  assign apply = wrap && pending_q;
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(tick);
    shadow_d = xfer ? pos_lim : shadow_q;
    pending_d = xfer || (pending_q && !wrap);
    width_d = apply ? CNT_W'(MIN_TICKS) + CNT_W'(shadow_q) : width_q;
    state_d = apply ? RUN : state_q;
    pwm_d = state_q == RUN && cnt_q < width_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      shadow_q <= '0;
      width_q <= '0;
      pending_q <= 1'b0;
      pwm_q <= 1'b0;
      fs_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      width_q <= width_d;
      pending_q <= pending_d;
      pwm_q <= pwm_d;
      fs_q <= wrap;
      state_q <= state_d;
    end
  end
  assign pos_ready = ~pending_q;
  assign pwm_out = pwm_q;
  assign frame_start = fs_q;
  assign active = state_q == RUN;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: table-driven command sequence plus corner-case sequences; pulse widths scoreboarded.
module tb_servo_pwm_gen;
  localparam int PERIOD = 20, MIN = 4, PW = 4, SP = 4;
`ifdef SERVO_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, pos_valid = 1'b0, sclk_run = 1'b0, sclk_man = 1'b0;
  logic sclk_in, pos_ready, pwm_out, frame_start, active;
  logic [PW-1:0] pos_data = '0;
  logic [1:0] ph = '0;
  int checks = 0, errors = 0;
  int exp_q[$];
  typedef struct {int pos; int width;} vec_t;
  vec_t vecs[5];

  servo_pwm_gen #(.PERIOD_TICKS(PERIOD), .MIN_TICKS(MIN), .POS_W(PW)
`ifdef SERVO_CLAMP_EN
    , .POS_MAX(10)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .pos_valid(pos_valid), .pos_data(pos_data),
    .pos_ready(pos_ready), .pwm_out(pwm_out), .frame_start(frame_start), .active(active)
  );

  always #5 clk = ~clk;
  assign sclk_in = sclk_run ? ph[1] : sclk_man;
  initial forever begin
    @(negedge clk);
    if (sclk_run) ph = ph + 2'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 300);
    chk("frame_seen", frame_start, 1);
  endtask

  task automatic send(input logic [PW-1:0] p);
    int n;
    n = 0;
    while (!pos_ready && n < 500) begin @(negedge clk); n++; end
    chk("ready_before_send", pos_ready, 1);
    pos_valid = 1'b1;
    pos_data = p;
    @(negedge clk);
    pos_valid = 1'b0;
    chk("ready_low_after_xfer", pos_ready, 0);
  endtask

  // Each completed pulse is checked against the next expected frame width.
  initial begin
    int hi, e;
    hi = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) hi = 0;
      else if (pwm_out) hi++;
      else if (hi != 0) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", hi, 0);
        else begin
          e = exp_q.pop_front();
          chk("pulse_width_clks", hi, e * SP);
        end
        hi = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, ticks, n;
    logic seen, acc, hi_seen;
    vecs[0] = '{3, 7};
    vecs[1] = '{0, 4};
    vecs[2] = '{15, CLAMP ? 14 : 19};
    vecs[3] = '{7, 11};
    vecs[4] = '{1, 5};
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ready", pos_ready, 1);
    chk("rst_active", active, 0);
    chk("rst_frame_start", frame_start, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sclk_man = 1'b1;
    @(negedge clk); chk("tick_edge1", dut.tick, 0);
    @(negedge clk); chk("tick_edge2", dut.tick, 0);
    @(negedge clk); chk("tick_edge3", dut.tick, 1);
    @(negedge clk); chk("tick_edge4", dut.tick, 0);
    ticks = 0;
    repeat (50) begin @(negedge clk); ticks += int'(dut.tick); end
    chk("held_high_ticks", ticks, 0);
    sclk_man = 1'b0;
    ticks = 0;
    repeat (20) begin @(negedge clk); ticks += int'(dut.tick); end
    chk("falling_edge_ticks", ticks, 0);
    chk("cnt_frozen", dut.cnt_q, 1);
    sclk_run = 1'b1;
    wait_frame();
    chk("idle_active", active, 0);
    cur = 0;
    foreach (vecs[i]) begin
      wait_frame();
      if (cur != 0) exp_q.push_back(cur);
      chk("active_state", active, cur != 0);
      send(vecs[i].pos[PW-1:0]);
      cur = vecs[i].width;
    end
    wait_frame();
    exp_q.push_back(cur);
    send(4'd5);
    pos_valid = 1'b1;
    pos_data = 4'd9;
    seen = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      if (frame_start) begin seen = 1'b1; exp_q.push_back(MIN + 5); end
      acc = pos_ready;
    end
    @(negedge clk);
    pos_valid = 1'b0;
    chk("bp_accepted", acc, 1);
    chk("bp_only_after_wrap", seen, 1);
    chk("bp_ready_low", pos_ready, 0);
    wait_frame();
    exp_q.push_back(MIN + 9);
    n = 0;
    while (!(dut.tick && dut.cnt_q == PERIOD - 1) && n < 300) begin @(negedge clk); n++; end
    chk("sim_ready", pos_ready, 1);
    pos_valid = 1'b1;
    pos_data = 4'd2;
    exp_q.push_back(MIN + 9);
    @(negedge clk);
    pos_valid = 1'b0;
    chk("sim_frame_start", frame_start, 1);
    chk("sim_ready_low", pos_ready, 0);
    wait_frame();
    exp_q.push_back(MIN + 2);
    wait_frame();
    exp_q.push_back(MIN + 2);
    n = 0;
    while (!pwm_out && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_pwm", pwm_out, 0);
    chk("midrst_ready", pos_ready, 1);
    chk("midrst_active", active, 0);
    chk("midrst_frame_start", frame_start, 0);
    exp_q.delete();
    sclk_man = 1'b0;
    sclk_run = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    hi_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      ticks += int'(dut.tick);
      hi_seen |= pwm_out;
    end
    chk("postrst_ticks", ticks, 0);
    chk("postrst_pwm", hi_seen, 0);
    chk("postrst_active", active, 0);
    sclk_run = 1'b1;
    send(4'd3);
    wait_frame();
    exp_q.push_back(MIN + 3);
    chk("postrst_run", active, 1);
    wait_frame();
    exp_q.push_back(MIN + 3);
    wait_frame();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
